// File: rtl/trace_nop_event_fifo.sv
// Per-core trace event extractor: shadows GPR r3, decodes simulation l.nop K
// instructions (putc/report/exit) and queues them in a ready/valid event FIFO.
module trace_nop_event_fifo #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      trace_valid,
    input  logic [31:0]               trace_insn,
    input  logic                      trace_wben,
    input  logic [4:0]                trace_wbreg,
    input  logic [31:0]               trace_wbdata,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [1:0]                evt_type,
    output logic [31:0]               evt_data,
    output logic                      terminated,
    output logic [31:0]               exit_code,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        EVT_PUTC   = 2'd0,
        EVT_REPORT = 2'd1,
        EVT_EXIT   = 2'd2
    } evtType_e;

    typedef struct packed {
        evtType_e    kind;
        logic [31:0] data;
    } evtEntry_t;

    logic [31:0]               r3_q, r3_d;
    logic                      terminated_q, terminated_d;
    logic [31:0]               exitCode_q, exitCode_d;
    logic                      overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0] dropCnt_q, dropCnt_d;
    logic [PTR_W-1:0]          wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]          rdPtr_q, rdPtr_d;

    evtEntry_t                 fifoMem [FIFO_DEPTH];
    evtEntry_t                 headEntry;
    evtEntry_t                 pushEntry;

    logic                      traceLive;
    logic                      isNop;
    logic                      isExit;
    logic                      pushReq;
    logic                      pushFire;
    logic                      pushDrop;
    logic                      popFire;
    logic                      fifoEmpty;
    logic                      fifoFull;
    logic [IDX_W-1:0]          wrIdx;
    logic [IDX_W-1:0]          rdIdx;
    logic                      unusedInsnBits;

    assign unusedInsnBits = ^trace_insn[23:16];

    assign wrIdx     = wrPtr_q[IDX_W-1:0];
    assign rdIdx     = rdPtr_q[IDX_W-1:0];
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[PTR_W-1] != rdPtr_q[PTR_W-1]) &&
                       (wrIdx == rdIdx);
    assign headEntry = fifoMem[rdIdx];

    // Once the exit nop has retired the core is considered dead; nothing more
    // from the trace is allowed to touch r3 or generate events.
    always_comb begin
        traceLive      = trace_valid && !terminated_q;
        isNop          = traceLive && (trace_insn[31:24] == 8'h15);
        isExit         = 1'b0;
        pushReq        = 1'b0;
        pushEntry.kind = EVT_PUTC;
        pushEntry.data = 32'h0;
        if (isNop) begin
            case (trace_insn[15:0])
                16'h0004: begin
                    pushReq        = 1'b1;
                    pushEntry.kind = EVT_PUTC;
                    pushEntry.data = {24'h0, r3_q[7:0]};
                end
                16'h0002: begin
                    pushReq        = 1'b1;
                    pushEntry.kind = EVT_REPORT;
                    pushEntry.data = r3_q;
                end
                16'h0001: begin
                    pushReq        = 1'b1;
                    isExit         = 1'b1;
                    pushEntry.kind = EVT_EXIT;
                    pushEntry.data = r3_q;
                end
                default: ;
            endcase
        end
    end

    // A full FIFO still takes a push when the head leaves in the same cycle,
    // since the freed slot is exactly the one being written.
    always_comb begin
        popFire  = !fifoEmpty && evt_ready;
        pushFire = pushReq && (!fifoFull || popFire);
        pushDrop = pushReq && !pushFire;

        r3_d         = r3_q;
        terminated_d = terminated_q;
        exitCode_d   = exitCode_q;
        overflow_d   = overflow_q;
        dropCnt_d    = dropCnt_q;
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;

        if (traceLive && trace_wben && (trace_wbreg == 5'd3)) begin
            r3_d = trace_wbdata;
        end
        if (isExit) begin
            terminated_d = 1'b1;
            exitCode_d   = r3_q;
        end
        if (pushDrop) begin
            overflow_d = 1'b1;
            if (dropCnt_q != '1) begin
                dropCnt_d = dropCnt_q + DROP_CNT_WIDTH'(1);
            end
        end
        if (pushFire) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popFire) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_q         <= 32'h0;
            terminated_q <= 1'b0;
            exitCode_q   <= 32'h0;
            overflow_q   <= 1'b0;
            dropCnt_q    <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
        end else begin
            r3_q         <= r3_d;
            terminated_q <= terminated_d;
            exitCode_q   <= exitCode_d;
            overflow_q   <= overflow_d;
            dropCnt_q    <= dropCnt_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushFire) begin
            fifoMem[wrIdx] <= pushEntry;
        end
    end

    // Storage is not reset, so the payload is forced to zero whenever the FIFO
    // is empty; this also hides any stale slot after a mid-run reset.
    assign evt_valid  = !fifoEmpty;
    assign evt_type   = fifoEmpty ? 2'd0  : headEntry.kind;
    assign evt_data   = fifoEmpty ? 32'h0 : headEntry.data;
    assign terminated = terminated_q;
    assign exit_code  = exitCode_q;
    assign overflow   = overflow_q;
    assign drop_count = dropCnt_q;

endmodule

// File: tb/tb_trace_nop_event_fifo.sv
// Self-checking bench for trace_nop_event_fifo: vector table plus hand-written
// sequences, with every transfer checked against an expected-event queue.
module tb_trace_nop_event_fifo;

    localparam int DEPTH = 8;
    localparam int DCW   = 16;
    localparam logic [31:0] NOP_EXIT   = 32'h15000001;
    localparam logic [31:0] NOP_REPORT = 32'h15000002;
    localparam logic [31:0] NOP_PUTC   = 32'h15000004;
    localparam logic [31:0] ORI_R3     = 32'hA8600000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           trace_valid = 1'b0;
    logic [31:0]    trace_insn = 32'h0;
    logic           trace_wben = 1'b0;
    logic [4:0]     trace_wbreg = 5'd0;
    logic [31:0]    trace_wbdata = 32'h0;
    logic           evt_valid;
    logic           evt_ready = 1'b0;
    logic [1:0]     evt_type;
    logic [31:0]    evt_data;
    logic           terminated;
    logic [31:0]    exit_code;
    logic           overflow;
    logic [DCW-1:0] drop_count;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] d;
    } evt_t;

    typedef struct {
        logic        valid;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic        expEvt;
        logic [1:0]  expType;
        logic [31:0] expData;
    } vec_t;

    evt_t        expQ[$];
    vec_t        vecs[14];
    int          total = 0;
    int          bad = 0;
    logic        stallPrev = 1'b0;
    logic [1:0]  stallType = 2'd0;
    logic [31:0] stallData = 32'h0;

    trace_nop_event_fifo #(
        .FIFO_DEPTH(DEPTH),
        .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .trace_valid(trace_valid),
        .trace_insn(trace_insn),
        .trace_wben(trace_wben),
        .trace_wbreg(trace_wbreg),
        .trace_wbdata(trace_wbdata),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_type(evt_type),
        .evt_data(evt_data),
        .terminated(terminated),
        .exit_code(exit_code),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expectEvt(input logic [1:0] t, input logic [31:0] d);
        evt_t e;
        e.t = t;
        e.d = d;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] insn, input logic wben,
                                 input logic [4:0] wbreg, input logic [31:0] wbdata);
        trace_valid  = v;
        trace_insn   = insn;
        trace_wben   = wben;
        trace_wbreg  = wbreg;
        trace_wbdata = wbdata;
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
        trace_wben  = 1'b0;
    endtask

    task automatic writeR3(input logic [31:0] v);
        applyStimulus(1'b1, ORI_R3, 1'b1, 5'd3, v);
    endtask

    task automatic retireNop(input logic [31:0] insn);
        applyStimulus(1'b1, insn, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Transfers are sampled mid-cycle; a stall seen on one negedge must still
    // show the same head on the next one.
    always @(negedge clk) begin
        if (!rst_n) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("stall_valid", {31'h0, evt_valid}, 32'h1);
                checkOutput("stall_type", {30'h0, evt_type}, {30'h0, stallType});
                checkOutput("stall_data", evt_data, stallData);
            end
            if (evt_valid && evt_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_evt: got type %0d data 0x%08h, expected none at %0t",
                             evt_type, evt_data, $time);
                end else begin
                    evt_t e;
                    e = expQ.pop_front();
                    checkOutput("evt_type", {30'h0, evt_type}, {30'h0, e.t});
                    checkOutput("evt_data", evt_data, e.d);
                end
            end
            stallPrev = evt_valid && !evt_ready;
            stallType = evt_type;
            stallData = evt_data;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, ORI_R3,        1'b1, 5'd3, 32'h00000041, 1'b0, 2'd0, 32'h0};
        vecs[1]  = '{1'b1, NOP_PUTC,      1'b0, 5'd0, 32'h0,        1'b1, 2'd0, 32'h00000041};
        vecs[2]  = '{1'b1, ORI_R3,        1'b1, 5'd3, 32'h12345678, 1'b0, 2'd0, 32'h0};
        vecs[3]  = '{1'b1, NOP_PUTC,      1'b0, 5'd0, 32'h0,        1'b1, 2'd0, 32'h00000078};
        vecs[4]  = '{1'b1, NOP_REPORT,    1'b0, 5'd0, 32'h0,        1'b1, 2'd1, 32'h12345678};
        vecs[5]  = '{1'b1, ORI_R3,        1'b1, 5'd4, 32'h0000FFFF, 1'b0, 2'd0, 32'h0};
        vecs[6]  = '{1'b1, NOP_REPORT,    1'b0, 5'd0, 32'h0,        1'b1, 2'd1, 32'h12345678};
        vecs[7]  = '{1'b1, 32'h15000003,  1'b0, 5'd0, 32'h0,        1'b0, 2'd0, 32'h0};
        vecs[8]  = '{1'b1, 32'h14000004,  1'b0, 5'd0, 32'h0,        1'b0, 2'd0, 32'h0};
        vecs[9]  = '{1'b0, NOP_PUTC,      1'b0, 5'd0, 32'h0,        1'b0, 2'd0, 32'h0};
        vecs[10] = '{1'b1, ORI_R3,        1'b0, 5'd3, 32'h0000CAFE, 1'b0, 2'd0, 32'h0};
        vecs[11] = '{1'b0, ORI_R3,        1'b1, 5'd3, 32'h00000BAD, 1'b0, 2'd0, 32'h0};
        vecs[12] = '{1'b1, NOP_PUTC,      1'b0, 5'd0, 32'h0,        1'b1, 2'd0, 32'h00000078};
        vecs[13] = '{1'b1, 32'h15AB0002,  1'b0, 5'd0, 32'h0,        1'b1, 2'd1, 32'h12345678};

        #2;
        checkOutput("rst_evt_valid", {31'h0, evt_valid}, 32'h0);
        checkOutput("rst_evt_type", {30'h0, evt_type}, 32'h0);
        checkOutput("rst_evt_data", evt_data, 32'h0);
        checkOutput("rst_terminated", {31'h0, terminated}, 32'h0);
        checkOutput("rst_exit_code", exit_code, 32'h0);
        checkOutput("rst_overflow", {31'h0, overflow}, 32'h0);
        checkOutput("rst_drop_count", {16'h0, drop_count}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        $display("[TB] vector table");
        evt_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].expEvt) expectEvt(vecs[i].expType, vecs[i].expData);
            applyStimulus(vecs[i].valid, vecs[i].insn, vecs[i].wben, vecs[i].wbreg, vecs[i].wbdata);
            checkOutput($sformatf("vec%0d_valid", i), {31'h0, evt_valid}, {31'h0, vecs[i].expEvt});
        end
        idle(2);
        checkOutput("table_drained", expQ.size(), 32'h0);

        $display("[TB] overflow with stalled consumer");
        evt_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            writeR3(32'h30 + i);
            if (i < DEPTH) expectEvt(2'd0, 32'h30 + i);
            retireNop(NOP_PUTC);
        end
        checkOutput("ovf_valid", {31'h0, evt_valid}, 32'h1);
        checkOutput("ovf_head", evt_data, 32'h30);
        checkOutput("ovf_flag", {31'h0, overflow}, 32'h1);
        checkOutput("ovf_drops", {16'h0, drop_count}, 32'd3);
        evt_ready = 1'b1;
        idle(DEPTH);
        checkOutput("ovf_empty", {31'h0, evt_valid}, 32'h0);
        checkOutput("ovf_drained", expQ.size(), 32'h0);

        $display("[TB] full plus simultaneous pop");
        evt_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            writeR3(32'h50 + i);
            expectEvt(2'd0, 32'h50 + i);
            retireNop(NOP_PUTC);
        end
        writeR3(32'h99);
        evt_ready = 1'b1;
        expectEvt(2'd0, 32'h99);
        retireNop(NOP_PUTC);
        checkOutput("fullpop_drops", {16'h0, drop_count}, 32'd3);
        checkOutput("fullpop_head", evt_data, 32'h51);
        idle(DEPTH + 1);
        checkOutput("fullpop_empty", {31'h0, evt_valid}, 32'h0);
        checkOutput("fullpop_drained", expQ.size(), 32'h0);

        $display("[TB] back-to-back with toggling ready");
        for (int k = 0; k < 3 * DEPTH / 2 + 1; k++) begin
            logic [31:0] r3v;
            r3v = 32'h12340000 + k * 3;
            evt_ready = ((3 * k) % 4) != 3;
            writeR3(r3v);
            evt_ready = ((3 * k + 1) % 4) != 3;
            expectEvt(2'd0, {24'h0, r3v[7:0]});
            retireNop(NOP_PUTC);
            evt_ready = ((3 * k + 2) % 4) != 3;
            expectEvt(2'd1, r3v);
            retireNop(NOP_REPORT);
        end
        evt_ready = 1'b1;
        idle(DEPTH + 2);
        checkOutput("b2b_drops", {16'h0, drop_count}, 32'd3);
        checkOutput("b2b_drained", expQ.size(), 32'h0);

        $display("[TB] reset with queued events");
        evt_ready = 1'b0;
        writeR3(32'h60);
        for (int i = 0; i < 4; i++) begin
            expectEvt(2'd0, 32'h60);
            retireNop(NOP_PUTC);
        end
        checkOutput("pre_rst_valid", {31'h0, evt_valid}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        expQ.delete();
        checkOutput("arst_valid", {31'h0, evt_valid}, 32'h0);
        checkOutput("arst_type", {30'h0, evt_type}, 32'h0);
        checkOutput("arst_data", evt_data, 32'h0);
        checkOutput("arst_overflow", {31'h0, overflow}, 32'h0);
        checkOutput("arst_drops", {16'h0, drop_count}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        evt_ready = 1'b1;
        idle(3);
        checkOutput("post_rst_valid", {31'h0, evt_valid}, 32'h0);
        expectEvt(2'd0, 32'h0);
        retireNop(NOP_PUTC);
        checkOutput("post_rst_evt", {31'h0, evt_valid}, 32'h1);
        idle(2);

        $display("[TB] report then exit");
        writeR3(32'hDEADBEEF);
        expectEvt(2'd1, 32'hDEADBEEF);
        retireNop(NOP_REPORT);
        writeR3(32'h5);
        expectEvt(2'd2, 32'h5);
        retireNop(NOP_EXIT);
        checkOutput("exit_term", {31'h0, terminated}, 32'h1);
        checkOutput("exit_code", exit_code, 32'h5);
        checkOutput("exit_valid", {31'h0, evt_valid}, 32'h1);
        writeR3(32'h77);
        retireNop(NOP_PUTC);
        retireNop(NOP_EXIT);
        retireNop(NOP_REPORT);
        idle(3);
        checkOutput("post_exit_code", exit_code, 32'h5);
        checkOutput("post_exit_term", {31'h0, terminated}, 32'h1);
        checkOutput("post_exit_valid", {31'h0, evt_valid}, 32'h0);
        checkOutput("final_drained", expQ.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_nop_event_fifo.md
# trace_nop_event_fifo

Synthesizable per-core event extractor that consumes the mor1kx execution trace of one compute-tile core and turns simulation-convention `l.nop K` instructions (putc, report, exit) into a buffered event stream. Sits directly downstream of the core trace port (`u_ct.trace[i]`). It replaces the behavioural r3 tracking and nop decoding of the simulation-only monitors, so the same events reach FPGA-side collectors or a debug-system bridge. Keeps a shadow copy of GPR r3, classifies nops, and queues events in a small FIFO with a ready/valid output.

## Interface
- `FIFO_DEPTH`, 8, event FIFO entries; power of two, ≥ 2
- `DROP_CNT_WIDTH`, 16, width of the saturating drop counter
- `clk`  in  1  system clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `trace_valid`  in  1  trace entry valid (one retired instruction)
- `trace_insn`  in  32  retired instruction word
- `trace_wben`  in  1  entry writes a GPR
- `trace_wbreg`  in  5  written GPR index
- `trace_wbdata`  in  32  written GPR value
- `evt_valid`  out  1  event available
- `evt_ready`  in  1  consumer accepts event
- `evt_type`  out  2  0=PUTC, 1=REPORT, 2=EXIT; 3 never generated
- `evt_data`  out  32  event payload
- `terminated`  out  1  sticky, exit nop retired
- `exit_code`  out  32  r3 at exit; held until reset
- `overflow`  out  1  sticky, at least one event dropped
- `drop_count`  out  DROP_CNT_WIDTH  dropped events, saturating at all-ones

## Operation
- Shadow r3: on `trace_valid && trace_wben && trace_wbreg==3` and not `terminated`, r3 ← `trace_wbdata`. Reset value 0.
- Nop decode: `trace_valid && trace_insn[31:24]==8'h15`; K = `trace_insn[15:0]`. K=0x0004 → PUTC, data `{24'h0, r3[7:0]}`; K=0x0002 → REPORT, data r3; K=0x0001 → EXIT, data r3. All other K: no event.
- Payload always uses the shadow r3 as registered before the current entry (a nop never writes back; no bypass needed).
- EXIT: `terminated`←1 and `exit_code`←r3 regardless of FIFO space; EXIT also queued if space. After `terminated`, all trace input ignored (no r3 update, no events). Queued events keep draining.
- FIFO: push accepted when not full, or when full and a pop occurs in the same cycle. Rejected push: `overflow`←1, `drop_count` += 1 (saturating). Out-of-order never; events leave in retirement order.
- Output handshake: transfer when `evt_valid && evt_ready`. `evt_type`/`evt_data` stable while `evt_valid && !evt_ready`. `evt_valid` never deasserts without a transfer, except by reset.
- Pointers are log2(FIFO_DEPTH)+1 bits; wrap naturally; full = MSBs differ and remaining bits equal; empty = equal.

## Timing
- Reset (asynchronous assert, synchronous release by design): `evt_valid`=0, `evt_type`=0, `evt_data`=0, `terminated`=0, `exit_code`=0, `overflow`=0, `drop_count`=0, FIFO empty, r3=0.
- Latency: nop retiring in cycle N → `evt_valid` high in cycle N+1 if FIFO was empty. `terminated` high in cycle N+1.
- Throughput: one push and one pop per cycle. Sustained one event/cycle with `evt_ready` held high.
- Reset mid-operation: FIFO contents discarded immediately, no partial transfer visible.

## Test plan
- r3 write 0x41 then `l.nop 4` (insn 0x15000004), `evt_ready`=1 → one cycle later `evt_valid`=1, type 0, data 0x00000041; one transfer only.
- r3←0xDEADBEEF, `l.nop 2`, then r3←0x5, `l.nop 1` → REPORT 0xDEADBEEF then EXIT 0x5 in order; `terminated`=1, `exit_code`=0x5; later r3 writes/nops produce nothing, and `exit_code` stays 0x5.
- `evt_ready`=0, FIFO_DEPTH+3 putc nops → FIFO_DEPTH events held, `overflow`=1, `drop_count`=3; release ready → exactly FIFO_DEPTH events drain in order; data stable during stall.
- FIFO full plus a putc retire in the same cycle as a pop → push accepted, `drop_count` unchanged.
- Back-to-back putc nops every cycle with ready toggling 1/0 → no loss, no duplication, order preserved across pointer wrap (≥3×FIFO_DEPTH events).
- `rst_n` pulsed low with 4 queued events → all outputs return to reset values asynchronously; no events after release until new nops retire.
